// File: rtl/arb_pkg.sv
// arb_pkg: FSM state encodings and default sizing shared by datapath_arbiter and rr_picker
package arb_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin search from ptr upward with wrap; ports req, ptr in; winner, valid out
module rr_picker
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     valid
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] idx;
  int j;
  always_comb begin
    winner = '0;
    idx = '0;
    j = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = j >= N_REQ ? j - N_REQ : j;
      idx = IW'(j);
      winner = req[idx] ? idx : winner;
    end
    valid = |req;
  end
endmodule

// File: rtl/datapath_arbiter.sv
// datapath_arbiter: round-robin owner of one datapath (clk, async active-low rst, req/grant/ack, dp_start/dp_done, busy; err and watchdog with ARB_TIMEOUT_EN)
module datapath_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ          = N_REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             dp_start,
  input  logic             dp_done,
  output logic [N_REQ-1:0] ack,
  output logic             busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             err
`endif
);
  localparam int IW = $clog2(N_REQ);
  state_t           state_q;
  logic [IW-1:0]    ptr_q, ptr_d, winner_q, pick;
  logic [N_REQ-1:0] grant_q, ack_q;
  logic             dp_start_q, valid, tmo;
  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .winner(pick),
    .valid (valid)
  );
  assign ptr_d    = winner_q == IW'(N_REQ - 1) ? '0 : winner_q + 1'b1;
  assign grant    = grant_q;
  assign ack      = ack_q;
  assign dp_start = dp_start_q;
  assign busy     = state_q != IDLE;
`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q;
  logic          err_q;
  assign err = err_q;
  assign tmo = wd_q == WW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= state_q == WAIT ? wd_q + 1'b1 : '0;
      err_q <= state_q == WAIT && tmo && !dp_done;
    end
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      winner_q   <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      dp_start_q <= 1'b0;
    end else begin
      ack_q      <= '0;
      dp_start_q <= 1'b0;
      case (state_q)
        IDLE:
          if (valid) begin
            state_q    <= START;
            winner_q   <= pick;
            grant_q    <= N_REQ'(1) << pick;
            dp_start_q <= 1'b1;
          end
        START: state_q <= WAIT;
        WAIT:
          if (dp_done || tmo) begin
            state_q <= ACK;
            grant_q <= '0;
            ack_q   <= grant_q;
            ptr_q   <= ptr_d;
          end
        ACK: state_q <= IDLE;
      endcase
    end
endmodule

// File: doc/datapath_arbiter.md
DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one iterative datapath; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: watchdog limit in clk cycles; used only with ARB_TIMEOUT_EN.
REQ-003 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset; asynchronous assert, active-low.
REQ-005 Port req  input  N_REQ  per-requester job request, level-sensitive.
REQ-006 Port grant  output  N_REQ  one-hot owner of the datapath; all-zero when no owner.
REQ-007 Port dp_start  output  1  start pulse to the datapath controller.
REQ-008 Port dp_done  input  1  completion pulse from the datapath controller.
REQ-009 Port ack  output  N_REQ  one-cycle completion pulse to the owning requester.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port err  output  1  one-cycle watchdog-abort pulse; exists only with ARB_TIMEOUT_EN.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, START, WAIT and ACK.
REQ-013 IDLE: if any req bit is high, the arbiter SHALL latch the round-robin winner and go to START; otherwise it SHALL stay in IDLE.
REQ-014 Round-robin: the search SHALL begin at index ptr and wrap from N_REQ-1 to 0; the lowest index at or after ptr with req high wins.
REQ-015 START: dp_start=1 for exactly one cycle, grant=one-hot(winner); the next state SHALL be WAIT unconditionally.
REQ-016 WAIT: grant held, dp_start=0; dp_done=1 SHALL cause a move to ACK; otherwise the arbiter SHALL stay in WAIT.
REQ-017 ACK: ack=one-hot(winner) for one cycle, grant=0; ptr SHALL become (winner+1) mod N_REQ; the next state SHALL be IDLE.
REQ-018 Latency: dp_start SHALL rise on the first clk edge after req is sampled high in IDLE; ack SHALL follow dp_done by 1 cycle.
REQ-019 dp_done SHALL be ignored in IDLE, START and ACK.
REQ-020 Changes on req SHALL NOT affect an owned job: a dropped req still completes and receives ack; a new req waits for IDLE.
REQ-021 Back-to-back jobs: after ACK, one IDLE cycle SHALL precede the next START, guaranteeing dp_start low for at least 1 cycle between jobs.
REQ-022 Simultaneous requests SHALL each be served exactly once per full rotation; no requester waits more than N_REQ-1 jobs.
REQ-023 grant SHALL never have more than one bit set; ack and grant SHALL never be high in the same cycle.

Reset
REQ-024 rst low SHALL asynchronously force: state=IDLE, ptr=0, grant=0, ack=0, dp_start=0, busy=0, err=0, watchdog=0.
REQ-025 Reset mid-job SHALL abort without an ack pulse; the datapath controller is reset by the same rst.

Configuration
REQ-026 With ARB_TIMEOUT_EN defined, a watchdog counter SHALL clear on entry to WAIT and increment each cycle in WAIT.
REQ-027 If the watchdog reaches TIMEOUT_CYCLES with dp_done still low, the arbiter SHALL go to ACK and pulse err with ack in the same cycle.
REQ-028 If dp_done is high in the same cycle the watchdog reaches TIMEOUT_CYCLES, done SHALL win and err SHALL stay 0.
REQ-029 Without ARB_TIMEOUT_EN, the err port and the counter SHALL be absent and WAIT SHALL be unbounded.

Structure
REQ-030 Shared package arb_pkg SHALL hold the state encodings (IDLE, START, WAIT, ACK) and the N_REQ and TIMEOUT_CYCLES defaults.
REQ-031 A combinational sub-module rr_picker (inputs req, ptr; outputs winner index and a valid flag) SHALL implement REQ-014.
REQ-032 Outputs SHALL be decoded from the registered state and winner only, with no combinational path from req to dp_start.

Verification
REQ-033 Single request: req=0010, dp_done pulsed 5 cycles after dp_start -> grant=0010 during START/WAIT, one dp_start pulse, ack=0010 one cycle after dp_done.
REQ-034 Contention: req=1111 held, ptr=0 -> service order 0,1,2,3,0 with exactly one ack per job.
REQ-035 Wrap: ptr=3, req=1001 -> winner 3, then winner 0.
REQ-036 Drop and stray done: req deasserted in WAIT -> job completes and ack still pulses; dp_done pulsed in IDLE -> no state change.
REQ-037 Reset: rst low during WAIT -> all outputs 0 asynchronously and no ack; after release, req=0100 -> winner 2 (ptr=0).
REQ-038 Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): no dp_done -> err and ack pulse together 8 cycles after WAIT entry; dp_done on cycle 8 -> err=0.
